ov7620_stream_gen: RTL and testbench
====================================

# ov7620_stream_gen

Synthesizable OV7620-style camera source. It generates PCLK, HREF, VSYNC and 8-bit pixel data from the system clock, with a programmable frame geometry and test patterns. It drives the capture path (PCLK edge detection, line/frame capture) on the board or in simulation, so the capture logic can be brought up without a sensor. It is the transmit end of the camera pin interface.

## Interface
- CLK_DIV, 2: system clocks per PCLK half-period (≥1)
- H_ACTIVE, 640: active pixel slots per line (1..2047)
- H_BLANK, 144: blank slots per line after the active pixels (≥1)
- V_ACTIVE, 480: active lines per frame (1..1023)
- VSYNC_LINES, 4: lines with VSYNC high (≥1)
- V_BACK, 16: blank lines between VSYNC and the first active line (≥0)

- CLK  in  1  system clock
- RSTn  in  1  reset, asynchronous, active-low
- Start_Sig  in  1  level; run while high, sampled at slot boundaries
- Pattern_Sel  in  2  0: x[7:0], 1: y[7:0], 2: x[7:0]^y[7:0], 3: 8'hA5
- Pin_PCLK  out  1  pixel clock
- Pin_HREF  out  1  line valid, high during active pixels
- Pin_VSYNC  out  1  frame sync, high during VSYNC lines
- Pin_Data  out  8  pixel data
- Frame_Done_Sig  out  1  one-CLK pulse at end of each frame

## Operation
- Divider counter div (0..2*CLK_DIV-1) free-runs whenever RSTn is high, including in IDLE. Pin_PCLK=0 for div<CLK_DIV and 1 otherwise.
- Slot = one PCLK period. Slot boundary = the CLK edge where div wraps to 0. All state, counter and output updates except PCLK and Frame_Done occur only at slot boundaries, so HREF, VSYNC and Data are stable around the PCLK rising edge.
- Every line is H_ACTIVE+H_BLANK slots long. The x counter counts slot-in-line; the y counter counts line-in-phase.
- States:
  - IDLE: all outputs 0 except PCLK. If Start_Sig=1 at a boundary, go to VSYNC and latch Pattern_Sel.
  - VSYNC: VSYNC_LINES lines; VSYNC=1, HREF=0. Then go to VBACK, or to ACTIVE if V_BACK=0.
  - VBACK: V_BACK lines; VSYNC=0, HREF=0. Then go to ACTIVE.
  - ACTIVE: V_ACTIVE lines. HREF=1 for x<H_ACTIVE, else 0.
  - After the last blank slot of the last active line: pulse Frame_Done_Sig. Go to VSYNC if Start_Sig=1 (re-latch Pattern_Sel), else go to IDLE.
- Data = pattern value when HREF=1, else 8'h00. x is the pixel index 0..H_ACTIVE-1 and y the active-line index 0..V_ACTIVE-1; only the low 8 bits are used, with natural wrap.
- Start_Sig deasserting mid-frame does not abort the frame; it completes.
- Pattern_Sel changes mid-frame are ignored until the next frame start.
- Reset mid-frame: all outputs drop to reset values immediately (asynchronous); state goes to IDLE.

## Timing
- Reset values: Pin_PCLK=0, Pin_HREF=0, Pin_VSYNC=0, Pin_Data=8'h00, Frame_Done_Sig=0, div=0, x=0, y=0, state IDLE.
- All outputs are registered; no combinational path from any input to any output.
- Start latency: VSYNC rises at the first slot boundary after Start_Sig is high, within 2*CLK_DIV CLK cycles.
- Line period = (H_ACTIVE+H_BLANK)*2*CLK_DIV CLK cycles.
- Frame period = (VSYNC_LINES+V_BACK+V_ACTIVE) line periods. Back-to-back frames have no gap.
- HREF rises at the first slot boundary of each active line, together with Data=pattern(0,y).
- Frame_Done_Sig is high for exactly one CLK, at the boundary that starts the next frame's first VSYNC slot or IDLE.

## Test plan
All scenarios use CLK_DIV=2, H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=2, V_BACK=1.
- Reset then idle 100 CLK -> PCLK toggles every 2 CLK; HREF, VSYNC and Data stay 0; Frame_Done stays 0.
- Start_Sig=1, Pattern_Sel=0, one frame -> VSYNC high 96 CLK; HREF low 48 CLK; then 4 lines each with HREF high 32 CLK; Data 0..7 sampled on PCLK rising edges; Frame_Done pulse at CLK 336 after VSYNC rise.
- Pattern_Sel=2 -> line y=3 yields 3,2,1,0,7,6,5,4. Pattern_Sel=3 -> all active data 8'hA5; Data is 0 in blanking.
- Start_Sig high for 3 frames, dropped mid-frame 3 -> frames spaced exactly 336 CLK apart; frame 3 completes; then IDLE with VSYNC 0.
- Loopback into a PCLK rising-edge detector plus HREF-qualified counter -> exactly 8 pixels per line and 4 lines per frame.
- RSTn pulsed low mid-active-line -> all outputs 0 asynchronously; after release, no VSYNC until the next Start_Sig boundary.

Source files
------------

// File: rtl/ov7620_stream_gen.sv
// OV7620-style camera source: generates PCLK, HREF, VSYNC and pixel data with a
// programmable frame geometry and test patterns, for bringing up a capture path.
module ov7620_stream_gen #(
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_BLANK     = 144,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned VSYNC_LINES = 4,
   parameter int unsigned V_BACK      = 16
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       Start_Sig,
   input  logic [1:0] Pattern_Sel,
   output logic       Pin_PCLK,
   output logic       Pin_HREF,
   output logic       Pin_VSYNC,
   output logic [7:0] Pin_Data,
   output logic       Frame_Done_Sig
);

   localparam int unsigned DW      = $clog2(2 * CLK_DIV);
   localparam int unsigned LineLen = H_ACTIVE + H_BLANK;
   localparam int unsigned XW      = $clog2(LineLen);
   localparam int unsigned YMax0   = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
   localparam int unsigned YMax    = (YMax0 > V_BACK) ? YMax0 : V_BACK;
   localparam int unsigned YW      = $clog2(YMax + 1);

   localparam logic [DW-1:0] DivLast  = DW'(2 * CLK_DIV - 1);
   localparam logic [DW-1:0] DivHalf  = DW'(CLK_DIV);
   localparam logic [XW-1:0] XLast    = XW'(LineLen - 1);
   localparam logic [XW-1:0] XAct     = XW'(H_ACTIVE);
   localparam logic [YW-1:0] YLastVs  = YW'(VSYNC_LINES - 1);
   localparam logic [YW-1:0] YLastVb  = YW'((V_BACK == 0) ? 0 : V_BACK - 1);
   localparam logic [YW-1:0] YLastAct = YW'(V_ACTIVE - 1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StVsync  = 2'd1;
   localparam logic [1:0] StVback  = 2'd2;
   localparam logic [1:0] StActive = 2'd3;

   logic [DW-1:0] div_q, div_d;
   logic          pclk_q, pclk_d;
   logic [1:0]    state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [1:0]    pat_q, pat_d;
   logic          href_q, href_d;
   logic          vsync_q, vsync_d;
   logic [7:0]    data_q, data_d;
   logic          done_q, done_d;
   logic          boundary;
   logic [YW-1:0] y_last;
   logic [7:0]    x8, y8, pat_val;

   always_comb begin
      case (state_q)
         StVsync: y_last = YLastVs;
         StVback: y_last = YLastVb;
         default: y_last = YLastAct;
      endcase
   end

   // Advance from the slot just ending to the slot starting at this boundary;
   // outputs are then registered from the new slot's coordinates.
   always_comb begin
      boundary = (div_q == DivLast);
      div_d    = boundary ? '0 : div_q + 1'b1;
      pclk_d   = (div_d >= DivHalf);
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      pat_d    = pat_q;
      done_d   = 1'b0;
      if (boundary) begin
         if (state_q == StIdle) begin
            if (Start_Sig) begin
               state_d = StVsync;
               x_d     = '0;
               y_d     = '0;
               pat_d   = Pattern_Sel;
            end
         end else if (x_q != XLast) begin
            x_d = x_q + 1'b1;
         end else begin
            x_d = '0;
            if (y_q != y_last) begin
               y_d = y_q + 1'b1;
            end else begin
               y_d = '0;
               case (state_q)
                  StVsync: state_d = (V_BACK == 0) ? StActive : StVback;
                  StVback: state_d = StActive;
                  default: begin
                     done_d = 1'b1;
                     if (Start_Sig) begin
                        state_d = StVsync;
                        pat_d   = Pattern_Sel;
                     end else begin
                        state_d = StIdle;
                     end
                  end
               endcase
            end
         end
      end
   end

   always_comb begin
      x8 = 8'(x_d);
      y8 = 8'(y_d);
      case (pat_d)
         2'd0:    pat_val = x8;
         2'd1:    pat_val = y8;
         2'd2:    pat_val = x8 ^ y8;
         default: pat_val = 8'hA5;
      endcase
      href_d  = href_q;
      vsync_d = vsync_q;
      data_d  = data_q;
      if (boundary) begin
         vsync_d = (state_d == StVsync);
         href_d  = (state_d == StActive) && (x_d < XAct);
         data_d  = href_d ? pat_val : 8'h00;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         div_q   <= '0;
         pclk_q  <= 1'b0;
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         pat_q   <= 2'd0;
         href_q  <= 1'b0;
         vsync_q <= 1'b0;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         div_q   <= div_d;
         pclk_q  <= pclk_d;
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pat_q   <= pat_d;
         href_q  <= href_d;
         vsync_q <= vsync_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign Pin_PCLK       = pclk_q;
   assign Pin_HREF       = href_q;
   assign Pin_VSYNC      = vsync_q;
   assign Pin_Data       = data_q;
   assign Frame_Done_Sig = done_q;

endmodule

// File: tb/tb_ov7620_stream_gen.sv
// Directed bench for ov7620_stream_gen with a small geometry; a negedge monitor
// acts as the capture side (PCLK rising-edge detector, HREF-qualified counters).
module tb_ov7620_stream_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] sel = 2'd0;
   logic       pclk, href, vsync, done;
   logic [7:0] data;

   int n_checks = 0;
   int n_errs   = 0;

   ov7620_stream_gen #(
      .CLK_DIV    (2),
      .H_ACTIVE   (8),
      .H_BLANK    (4),
      .V_ACTIVE   (4),
      .VSYNC_LINES(2),
      .V_BACK     (1)
   ) dut (
      .CLK           (clk),
      .RSTn          (rst_n),
      .Start_Sig     (start),
      .Pattern_Sel   (sel),
      .Pin_PCLK      (pclk),
      .Pin_HREF      (href),
      .Pin_VSYNC     (vsync),
      .Pin_Data      (data),
      .Frame_Done_Sig(done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Capture-side monitor, sampled on the falling CLK edge.
   logic       mon_clr = 1'b0;
   logic       pclk_p = 1'b0, href_p = 1'b0, vs_p = 1'b0, done_p = 1'b0;
   int         ncyc = 0, nframes = 0, ndone = 0, done_hi = 0, blank_nz = 0;
   int         line = 0, cur = 0, mf = 0, vs_fall_t = 0, href_rise_t = 0;
   int         vs_len = 0, back_len = 0;
   int         vs_rise_t [4];
   int         done_t [4];
   int         href_len [4];
   int         pixcnt [4];
   int         nlines [4];
   logic [7:0] pix [4][4][8];

   always @(negedge clk) begin
      if (mon_clr) begin
         nframes = 0; ndone = 0; done_hi = 0; blank_nz = 0; line = 0; cur = 0;
      end else begin
         if (vsync && !vs_p) begin
            if (nframes < 4) vs_rise_t[nframes] = ncyc;
            nframes++;
            line = 0;
         end
         mf = (nframes == 0) ? 0 : ((nframes > 4) ? 3 : nframes - 1);
         if (!vsync && vs_p) begin
            vs_len    = ncyc - vs_rise_t[mf];
            vs_fall_t = ncyc;
         end
         if (href && !href_p) begin
            if (line == 0) back_len = ncyc - vs_fall_t;
            cur = (line < 4) ? line : 3;
            line++;
            pixcnt[cur] = 0;
            nlines[mf]  = line;
            href_rise_t = ncyc;
         end
         if (!href && href_p) href_len[cur] = ncyc - href_rise_t;
         if (pclk && !pclk_p && href) begin
            if (pixcnt[cur] < 8) pix[mf][cur][pixcnt[cur]] = data;
            pixcnt[cur]++;
         end
         if (!href && data != 8'h00) blank_nz++;
         if (done) begin
            done_hi++;
            if (!done_p) begin
               if (ndone < 4) done_t[ndone] = ncyc;
               ndone++;
            end
         end
      end
      pclk_p = pclk; href_p = href; vs_p = vsync; done_p = done;
      ncyc++;
   end

   task automatic clear_mon();
      mon_clr = 1'b1;
      tick(1);
      mon_clr = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int bad_pclk, bad_idle, lat, k;

      // Reset and idle
      #3;
      check_eq("reset_outputs", {pclk, href, vsync, done, data}, 12'h000);
      tick(2);
      rst_n = 1'b1;
      bad_pclk = 0;
      bad_idle = 0;
      for (int i = 1; i <= 100; i++) begin
         tick(1);
         if (pclk !== ((i % 4 == 2) || (i % 4 == 3))) bad_pclk++;
         if ({href, vsync, done, data} !== 11'h000) bad_idle++;
      end
      check_eq("idle_pclk_errors", bad_pclk, 0);
      check_eq("idle_output_errors", bad_idle, 0);

      // Single frame, pattern x
      clear_mon();
      sel   = 2'd0;
      start = 1'b1;
      lat   = 0;
      while (!vsync && lat < 20) begin
         tick(1);
         lat++;
      end
      check_eq("start_latency_ok", (lat >= 1 && lat <= 4), 1);
      start = 1'b0;
      k = 0;
      while (ndone < 1 && k < 1000) begin
         tick(1);
         k++;
      end
      check_eq("frameA_done_seen", ndone >= 1, 1);
      check_eq("frameA_vsync_len", vs_len, 96);
      check_eq("frameA_back_len", back_len, 48);
      check_eq("frameA_lines", nlines[0], 4);
      for (int l = 0; l < 4; l++) begin
         check_eq($sformatf("frameA_href_len_l%0d", l), href_len[l], 32);
         check_eq($sformatf("frameA_pixels_l%0d", l), pixcnt[l], 8);
      end
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("pat0_y0_x%0d", i), pix[0][0][i], i);
         check_eq($sformatf("pat0_y3_x%0d", i), pix[0][3][i], i);
      end
      check_eq("frameA_done_offset", done_t[0] - vs_rise_t[0], 336);
      tick(400);
      check_eq("frameA_done_width", done_hi, 1);
      check_eq("frameA_no_restart", nframes, 1);
      check_eq("frameA_idle_vsync", vsync, 0);

      // Three back-to-back frames; mid-frame Pattern_Sel changes apply next frame
      clear_mon();
      sel   = 2'd2;
      start = 1'b1;
      k = 0;
      while (nframes < 1 && k < 100) begin tick(1); k++; end
      tick(50);
      sel = 2'd3;
      k = 0;
      while (nframes < 2 && k < 600) begin tick(1); k++; end
      tick(50);
      sel = 2'd1;
      k = 0;
      while (nframes < 3 && k < 600) begin tick(1); k++; end
      check_eq("multi_third_frame_started", nframes, 3);
      tick(100);
      start = 1'b0;
      k = 0;
      while (ndone < 3 && k < 600) begin tick(1); k++; end
      tick(400);
      check_eq("multi_done_count", ndone, 3);
      check_eq("multi_frame_count", nframes, 3);
      check_eq("multi_idle_vsync", vsync, 0);
      check_eq("multi_spacing_1", vs_rise_t[1] - vs_rise_t[0], 336);
      check_eq("multi_spacing_2", vs_rise_t[2] - vs_rise_t[1], 336);
      check_eq("multi_last_done", done_t[2] - vs_rise_t[2], 336);
      check_eq("multi_blank_data_zero", blank_nz, 0);
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("pat2_y3_x%0d", i), pix[0][3][i], 3 ^ i);
         check_eq($sformatf("pat3_y1_x%0d", i), pix[1][1][i], 8'hA5);
         check_eq($sformatf("pat1_y2_x%0d", i), pix[2][2][i], 2);
      end

      // Asynchronous reset in the middle of an active line
      clear_mon();
      sel   = 2'd3;
      start = 1'b1;
      k = 0;
      while (!href && k < 400) begin tick(1); k++; end
      check_eq("rst_reached_active", href, 1);
      tick(5);
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_async_outputs", {pclk, href, vsync, done, data}, 12'h000);
      tick(3);
      rst_n = 1'b1;
      clear_mon();
      tick(60);
      check_eq("rst_no_vsync_after", nframes, 0);
      check_eq("rst_vsync_low", vsync, 0);
      start = 1'b1;
      lat   = 0;
      while (!vsync && lat < 20) begin
         tick(1);
         lat++;
      end
      check_eq("rst_restart_latency_ok", (lat >= 1 && lat <= 4), 1);
      start = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
